// File: rtl/mnist_pkg.sv
// mnist_pkg
// Shared definitions for the MNIST CNN pipeline back end.
//   argmaxState_t   : argmax_classifier FSM state encoding
//   mostNegative()  : most negative two's-complement value of a given width
//   DEFAULT_CLASS_COUNT : number of output classes of the network
package mnist_pkg;

  localparam int DEFAULT_CLASS_COUNT = 10;

  typedef enum logic [1:0] {
    ARGMAX_IDLE = 2'd0,
    ARGMAX_SCAN = 2'd1,
    ARGMAX_DONE = 2'd2
  } argmaxState_t;

  // Returns a 64-bit word whose low 'width' bits hold the most negative
  // value of that width (MSB set, rest clear); callers slice [width-1:0].
  function automatic logic [63:0] mostNegative(input int width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/argmax_classifier_if.sv
// argmax_classifier_if
// Score read port and result handshake of the argmax classifier.
//   start, busy                          : scan request / scan in progress
//   scoreAdr, scoreData                  : combinational read of the dense output buffer
//   classIdx, classScore, resultValid    : result, held until resultAck
//   resultAck                            : consumer accepts the result
//   margin                               : best minus second best (ARGMAX_MARGIN_EN only)
// Modports: slave = classifier side, master = controller/consumer side.
interface argmax_classifier_if
  import mnist_pkg::*;
#(
  parameter int CLASS_COUNT = DEFAULT_CLASS_COUNT,
  parameter int DATA_SIZE   = 32
);
  localparam int ADR_SIZE = $clog2(CLASS_COUNT);

  logic                        start;
  logic                        busy;
  logic [ADR_SIZE-1:0]         scoreAdr;
  logic signed [DATA_SIZE-1:0] scoreData;
  logic [ADR_SIZE-1:0]         classIdx;
  logic signed [DATA_SIZE-1:0] classScore;
  logic                        resultValid;
  logic                        resultAck;
`ifdef ARGMAX_MARGIN_EN
  logic signed [DATA_SIZE-1:0] margin;
`endif

  modport slave (
    input  start, scoreData, resultAck,
    output busy, scoreAdr, classIdx, classScore, resultValid
`ifdef ARGMAX_MARGIN_EN
    , output margin
`endif
  );

  modport master (
    output start, scoreData, resultAck,
    input  busy, scoreAdr, classIdx, classScore, resultValid
`ifdef ARGMAX_MARGIN_EN
    , input margin
`endif
  );

endinterface

// File: rtl/LoopCounter.sv
// LoopCounter
// Index counter 0..COUNT-1 that wraps to 0 after the last value.
//   clk, rst : clock, synchronous active-high reset
//   en       : advance one step
//   clr      : force to 0 (has priority over en)
//   cnt      : current index
//   co       : carry out, high while enabled on the last index
module LoopCounter #(
  parameter int COUNT    = 10,
  parameter int CNT_SIZE = $clog2(COUNT)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                clr,
  output logic [CNT_SIZE-1:0] cnt,
  output logic                co
);
  localparam logic [CNT_SIZE-1:0] LAST = CNT_SIZE'(COUNT - 1);

  assign co = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= co ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/argmax_classifier.sv
// argmax_classifier
// Scans CLASS_COUNT signed scores from the dense output buffer and reports
// the index and value of the largest one (lowest index wins on ties).
//   clk, rst : clock, synchronous active-high reset
//   bus      : argmax_classifier_if.slave (start/busy, score read port,
//              result with valid/ack handshake, optional margin)
// Optional feature: define ARGMAX_MARGIN_EN to track the second best score
// and present margin = best - second (saturated) with the result.
//
// state       | meaning
// ARGMAX_IDLE | waiting for start, best/second held at most negative
// ARGMAX_SCAN | one score compared per cycle, scoreAdr = index
// ARGMAX_DONE | result valid, waiting for resultAck or a new start
module argmax_classifier
  import mnist_pkg::*;
#(
  parameter int CLASS_COUNT = DEFAULT_CLASS_COUNT,
  parameter int DATA_SIZE   = 32
) (
  input logic                clk,
  input logic                rst,
  argmax_classifier_if.slave bus
);
  localparam int ADR_SIZE = $clog2(CLASS_COUNT);
  localparam logic [63:0] MOST_NEG_W = mostNegative(DATA_SIZE);
  localparam logic signed [DATA_SIZE-1:0] MOST_NEG = MOST_NEG_W[DATA_SIZE-1:0];

  argmaxState_t                state;
  logic                        busyReg;
  logic                        validReg;
  logic [ADR_SIZE-1:0]         classIdxReg;
  logic signed [DATA_SIZE-1:0] classScoreReg;

  logic [ADR_SIZE-1:0]         cnt;
  logic                        co;
  logic signed [DATA_SIZE-1:0] best;
  logic [ADR_SIZE-1:0]         bestIdx;
  logic signed [DATA_SIZE-1:0] nextBest;
  logic [ADR_SIZE-1:0]         nextBestIdx;
  logic                        take;

  LoopCounter #(.COUNT(CLASS_COUNT), .CNT_SIZE(ADR_SIZE)) uScanCnt (
    .clk (clk),
    .rst (rst),
    .en  (state == ARGMAX_SCAN),
    .clr (state == ARGMAX_IDLE),
    .cnt (cnt),
    .co  (co)
  );

  // Strict compare keeps the first occurrence on ties.
  assign take        = bus.scoreData > best;
  assign nextBest    = take ? bus.scoreData : best;
  assign nextBestIdx = take ? cnt : bestIdx;

`ifdef ARGMAX_MARGIN_EN
  localparam logic signed [DATA_SIZE-1:0] MAX_POS = {1'b0, {(DATA_SIZE-1){1'b1}}};

  logic signed [DATA_SIZE-1:0] second;
  logic signed [DATA_SIZE-1:0] nextSecond;
  logic signed [DATA_SIZE:0]   diff;
  logic signed [DATA_SIZE-1:0] marginSat;
  logic signed [DATA_SIZE-1:0] marginReg;

  assign nextSecond = take ? best
                    : ((bus.scoreData > second) ? bus.scoreData : second);
  assign diff = {nextBest[DATA_SIZE-1], nextBest} - {nextSecond[DATA_SIZE-1], nextSecond};
  // best >= second always, so the only overflow is past the positive maximum.
  assign marginSat = (diff[DATA_SIZE] != diff[DATA_SIZE-1]) ? MAX_POS : diff[DATA_SIZE-1:0];
  assign bus.margin = marginReg;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ARGMAX_IDLE;
      busyReg       <= 1'b0;
      validReg      <= 1'b0;
      classIdxReg   <= '0;
      classScoreReg <= '0;
      best          <= MOST_NEG;
      bestIdx       <= '0;
`ifdef ARGMAX_MARGIN_EN
      second        <= MOST_NEG;
      marginReg     <= '0;
`endif
    end else begin
      case (state)
        ARGMAX_IDLE: begin
          best    <= MOST_NEG;
          bestIdx <= '0;
`ifdef ARGMAX_MARGIN_EN
          second  <= MOST_NEG;
`endif
          if (bus.start) begin
            state   <= ARGMAX_SCAN;
            busyReg <= 1'b1;
          end
        end
        ARGMAX_SCAN: begin
          best    <= nextBest;
          bestIdx <= nextBestIdx;
`ifdef ARGMAX_MARGIN_EN
          second  <= nextSecond;
`endif
          if (co) begin
            state         <= ARGMAX_DONE;
            busyReg       <= 1'b0;
            validReg      <= 1'b1;
            classIdxReg   <= nextBestIdx;
            classScoreReg <= nextBest;
`ifdef ARGMAX_MARGIN_EN
            marginReg     <= marginSat;
`endif
          end
        end
        ARGMAX_DONE: begin
          // start doubles as an acknowledge and launches a fresh scan.
          if (bus.start) begin
            state    <= ARGMAX_SCAN;
            busyReg  <= 1'b1;
            validReg <= 1'b0;
            best     <= MOST_NEG;
            bestIdx  <= '0;
`ifdef ARGMAX_MARGIN_EN
            second   <= MOST_NEG;
`endif
          end else if (bus.resultAck) begin
            state    <= ARGMAX_IDLE;
            validReg <= 1'b0;
          end
        end
        default: begin
          state    <= ARGMAX_IDLE;
          busyReg  <= 1'b0;
          validReg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = busyReg;
  assign bus.resultValid = validReg;
  assign bus.classIdx    = classIdxReg;
  assign bus.classScore  = classScoreReg;
  assign bus.scoreAdr    = cnt;

endmodule

// File: tb/tb_argmax_classifier.sv
// Self-checking bench for argmax_classifier: directed scenarios plus
// randomized score sets, all checked every cycle against a behavioural model.
module tb_argmax_classifier;
  localparam int N = 10;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  argmax_classifier_if #(.CLASS_COUNT(N), .DATA_SIZE(W)) bus ();

  argmax_classifier #(.CLASS_COUNT(N), .DATA_SIZE(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic signed [W-1:0] mem [16];
  assign bus.scoreData = mem[bus.scoreAdr];

  int nChecks = 0;
  int nFail   = 0;
  int cyc     = 0;

  // model state
  int                  scanLeft  = 0;
  bit                  resValid  = 1'b0;
  int                  expIdx    = 0;
  logic signed [W-1:0] expScore  = '0;
  logic signed [W-1:0] expMargin = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic signed [W-1:0] fx(input int v);
    return v * 65536;
  endfunction

  // Reference: index of first maximum, its value, and max minus the
  // second largest element of the multiset, clipped to the positive max.
  task automatic refArgmax(output int idx, output logic signed [W-1:0] bestV,
                           output logic signed [W-1:0] marg);
    longint b, s, d;
    idx = 0;
    b = longint'(mem[0]);
    for (int i = 1; i < N; i++)
      if (longint'(mem[i]) > b) begin b = longint'(mem[i]); idx = i; end
    s = -64'sd2147483648;
    for (int i = 0; i < N; i++)
      if (i != idx && longint'(mem[i]) > s) s = longint'(mem[i]);
    d = b - s;
    if (d > 64'sd2147483647) d = 64'sd2147483647;
    bestV = b[W-1:0];
    marg  = d[W-1:0];
  endtask

  // Model update on each rising edge, compare on each falling edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        scanLeft = 0; resValid = 0; expIdx = 0; expScore = '0; expMargin = '0;
      end else if (scanLeft > 0) begin
        scanLeft--;
        if (scanLeft == 0) begin
          resValid = 1'b1;
          refArgmax(expIdx, expScore, expMargin);
        end
      end else if (bus.start) begin
        scanLeft = N;
        resValid = 1'b0;
      end else if (bus.resultAck) begin
        resValid = 1'b0;
      end
      @(negedge clk);
      check("busy", bus.busy, scanLeft > 0);
      check("resultValid", bus.resultValid, resValid);
      check("scoreAdr", bus.scoreAdr, (scanLeft > 0) ? N - scanLeft : 0);
      check("classIdx", bus.classIdx, expIdx);
      check("classScore", bus.classScore, expScore);
`ifdef ARGMAX_MARGIN_EN
      check("margin", bus.margin, expMargin);
`endif
    end
  end

  task automatic pulseStart(output int sc);
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    sc = cyc;
  endtask

  task automatic startAck(output int sc);
    @(negedge clk); bus.start = 1'b1; bus.resultAck = 1'b1;
    @(negedge clk); bus.start = 1'b0; bus.resultAck = 1'b0;
    sc = cyc;
  endtask

  task automatic ackPulse();
    @(negedge clk); bus.resultAck = 1'b1;
    @(negedge clk); bus.resultAck = 1'b0;
  endtask

  task automatic waitValid(input int sc, input string name);
    int lat;
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      if (bus.resultValid === 1'b1) begin lat = cyc - sc; break; end
      @(negedge clk);
    end
    if (lat < 0) begin
      nChecks++; nFail++;
      $display("FAIL %s: resultValid never rose within 40 cycles", name);
    end else begin
      check({name, " latency"}, lat, 10);
    end
  endtask

  task automatic loadInts(input int v [N]);
    for (int i = 0; i < N; i++) mem[i] = fx(v[i]);
  endtask

  task automatic randomMem();
    for (int i = 0; i < N; i++) begin
      case ($urandom_range(0, 3))
        0: mem[i] = $urandom();
        1: mem[i] = fx(int'($urandom_range(0, 6)) - 3);
        2: mem[i] = $urandom_range(0, 1) ? 32'h7FFF_FFFF : 32'h8000_0000;
        default: mem[i] = fx(int'($urandom_range(0, 200)) - 100);
      endcase
    end
  endtask

  int t1 [N] = '{0, 5, 3, 9, 1, 2, 9, 0, -4, 7};
  int t2 [N] = '{-8, -3, -5, -6, -7, -9, -10, -11, -12, -9};
  int sc;

  initial begin
    rst = 1'b1; bus.start = 1'b0; bus.resultAck = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    check("reset busy", bus.busy, 0);
    check("reset resultValid", bus.resultValid, 0);
    check("reset classScore", bus.classScore, 0);
    rst = 1'b0;

    // tie between index 3 and 6, plus an ignored start mid-scan
    loadInts(t1);
    pulseStart(sc);
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    check("t1 busy mid-scan", bus.busy, 1);
    waitValid(sc, "t1");
    check("t1 classIdx", bus.classIdx, 3);
    check("t1 classScore", bus.classScore, 32'sh0009_0000);
    check("t1 model idx", expIdx, 3);
`ifdef ARGMAX_MARGIN_EN
    check("t1 margin", bus.margin, 0);
`endif
    repeat (5) @(negedge clk);
    check("t1 hold valid", bus.resultValid, 1);
    check("t1 hold classIdx", bus.classIdx, 3);
    ackPulse();
    check("t1 ack clears valid", bus.resultValid, 0);

    // all negative
    loadInts(t2);
    pulseStart(sc);
    waitValid(sc, "t2");
    check("t2 classIdx", bus.classIdx, 1);
    check("t2 classScore", bus.classScore, 64'hFFFF_FFFF_FFFD_0000);
`ifdef ARGMAX_MARGIN_EN
    check("t2 margin", bus.margin, 32'h0002_0000);
`endif

    // start together with ack in DONE
    randomMem();
    startAck(sc);
    waitValid(sc, "startAck");
    ackPulse();

    // reset mid-scan, then a fresh scan
    loadInts(t1);
    pulseStart(sc);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst busy", bus.busy, 0);
    check("rst resultValid", bus.resultValid, 0);
    check("rst classIdx", bus.classIdx, 0);
    check("rst scoreAdr", bus.scoreAdr, 0);
    rst = 1'b0;
    loadInts(t2);
    pulseStart(sc);
    waitValid(sc, "after rst");
    check("after rst classIdx", bus.classIdx, 1);
    ackPulse();

    // all equal
    for (int i = 0; i < N; i++) mem[i] = fx(4);
    pulseStart(sc);
    waitValid(sc, "equal");
    check("equal classIdx", bus.classIdx, 0);
    ackPulse();

    // all most negative
    for (int i = 0; i < N; i++) mem[i] = 32'h8000_0000;
    pulseStart(sc);
    waitValid(sc, "allneg");
    check("allneg classIdx", bus.classIdx, 0);
    check("allneg classScore", bus.classScore, 64'hFFFF_FFFF_8000_0000);
    ackPulse();

    // full-range spread: margin saturates
    for (int i = 0; i < N; i++) mem[i] = 32'h8000_0000;
    mem[4] = 32'h7FFF_FFFF;
    pulseStart(sc);
    waitValid(sc, "sat");
    check("sat classIdx", bus.classIdx, 4);
    check("sat classScore", bus.classScore, 32'h7FFF_FFFF);
`ifdef ARGMAX_MARGIN_EN
    check("sat margin", bus.margin, 32'h7FFF_FFFF);
`endif

    // randomized score sets with random hold and ack style
    for (int it = 0; it < 30; it++) begin
      randomMem();
      if (bus.resultValid && $urandom_range(0, 1) == 1) begin
        startAck(sc);
      end else begin
        if (bus.resultValid) ackPulse();
        pulseStart(sc);
      end
      waitValid(sc, "random");
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
